// File: rtl/idli_sqi_mem.sv
// idli_sqi_mem: SQI (quad-SPI) serial SRAM model backing one byte lane of
// the idli core's external memory. Decodes the 4-bit command/address/data
// stream and serves byte READ (0x03) and WRITE (0x02) bursts from data_q.
// SCK is treated as a strobe sampled by the system clock i_sqi_gck.
// Optional feature: define IDLI_SQI_MEM_DUMMY_EN to insert the 2-nibble
// dummy phase between address and data on READ (23LC1024 SQI timing).
module idli_sqi_mem #(
    parameter int DEPTH = 65536,
    parameter int AW    = 24
) (
    input  logic       i_sqi_gck,
    input  logic       i_sqi_rst,
    input  logic       i_sqi_sck,
    input  logic       i_sqi_cs,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // Byte storage; deliberately untouched by reset so preloaded or
    // written contents survive a reset pulse.
    logic [7:0] data_q [DEPTH];

    state_t        r_state;
    logic          r_sck;
    logic [2:0]    r_cnt;
    logic [3:0]    r_cmd_hi;
    logic          r_read;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_hi;
    logic          r_lo_phase;

    logic          w_rise;
    logic [AW-1:0] w_addr_inc;
    logic [7:0]    w_byte_cur;
    logic [7:0]    w_byte_inc;
    logic          w_we;

    // The 24-bit stream address is folded into the array by modulo DEPTH.
    function automatic logic [IW-1:0] f_idx(input logic [AW-1:0] a);
        return IW'(32'(a) % 32'(DEPTH));
    endfunction

    assign w_rise     = i_sqi_cs && !r_sck && i_sqi_sck;
    assign w_addr_inc = r_addr + AW'(1);
    assign w_byte_cur = data_q[f_idx(r_addr)];
    assign w_byte_inc = data_q[f_idx(w_addr_inc)];
    assign w_we       = !i_sqi_rst && w_rise && (r_state == ST_DATA) &&
                        !r_read && r_lo_phase;

`ifndef IDLI_SQI_MEM_DUMMY_EN
    logic [AW-1:0] w_addr_shift_rd;
    logic [7:0]    w_byte_shift;
    // Without the dummy phase the first data nibble must come from the
    // address that the final address nibble is completing right now.
    assign w_addr_shift_rd = {r_addr[AW-5:0], i_sqi_sio};
    assign w_byte_shift    = data_q[f_idx(w_addr_shift_rd)];
`endif

    // Protocol state machine: command, address, dummy and data phases,
    // all advanced only on sampled SCK rises while chip select is high.
    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            r_state    <= ST_CMD;
            r_sck      <= 1'b0;
            r_cnt      <= 3'd0;
            r_cmd_hi   <= 4'd0;
            r_read     <= 1'b0;
            r_addr     <= '0;
            r_hi       <= 4'd0;
            r_lo_phase <= 1'b0;
            o_sqi_sio  <= 4'd0;
        end else begin
            r_sck <= i_sqi_sck;
            if (!i_sqi_cs) begin
                r_state    <= ST_CMD;
                r_cnt      <= 3'd0;
                r_cmd_hi   <= 4'd0;
                r_read     <= 1'b0;
                r_addr     <= '0;
                r_hi       <= 4'd0;
                r_lo_phase <= 1'b0;
                o_sqi_sio  <= 4'd0;
            end else if (w_rise) begin
                case (r_state)
                    ST_CMD: begin
                        if (r_cnt == 3'd0) begin
                            r_cmd_hi <= i_sqi_sio;
                            r_cnt    <= 3'd1;
                        end else begin
                            r_cnt <= 3'd0;
                            case ({r_cmd_hi, i_sqi_sio})
                                8'h03: begin
                                    r_read  <= 1'b1;
                                    r_state <= ST_ADDR;
                                end
                                8'h02: begin
                                    r_read  <= 1'b0;
                                    r_state <= ST_ADDR;
                                end
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        r_addr <= {r_addr[AW-5:0], i_sqi_sio};
                        if (r_cnt == 3'd5) begin
                            r_cnt      <= 3'd0;
                            r_lo_phase <= 1'b0;
                            if (r_read) begin
`ifdef IDLI_SQI_MEM_DUMMY_EN
                                r_state <= ST_DUMMY;
`else
                                r_state   <= ST_DATA;
                                o_sqi_sio <= w_byte_shift[7:4];
`endif
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    ST_DUMMY: begin
                        if (r_cnt == 3'd1) begin
                            r_cnt     <= 3'd0;
                            r_state   <= ST_DATA;
                            o_sqi_sio <= w_byte_cur[7:4];
                        end else begin
                            r_cnt <= 3'd1;
                        end
                    end
                    ST_DATA: begin
                        if (r_read) begin
                            if (!r_lo_phase) begin
                                o_sqi_sio  <= w_byte_cur[3:0];
                                r_lo_phase <= 1'b1;
                            end else begin
                                o_sqi_sio  <= w_byte_inc[7:4];
                                r_addr     <= w_addr_inc;
                                r_lo_phase <= 1'b0;
                            end
                        end else begin
                            if (!r_lo_phase) begin
                                r_hi       <= i_sqi_sio;
                                r_lo_phase <= 1'b1;
                            end else begin
                                r_addr     <= w_addr_inc;
                                r_lo_phase <= 1'b0;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        o_sqi_sio <= 4'd0;
                    end
                    default: begin
                        r_state <= ST_CMD;
                    end
                endcase
            end
        end
    end

    // Byte write on the rise carrying the low nibble of a WRITE data byte.
    always_ff @(posedge i_sqi_gck) begin
        if (w_we) begin
            data_q[f_idx(r_addr)] <= {r_hi, i_sqi_sio};
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed self-checking bench for idli_sqi_mem. Expected read nibbles are
// taken from a bench-side memory model and queued when each READ is issued,
// then popped and compared as the DUT presents them.
module tb_idli_sqi_mem;

    localparam int DEPTH = 65536;

    logic       gck;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] sioIn;
    logic [3:0] sioOut;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model [int];
    logic [3:0] expQ [$];

    idli_sqi_mem #(.DEPTH(DEPTH), .AW(24)) dut (
        .i_sqi_gck(gck),
        .i_sqi_rst(rst),
        .i_sqi_sck(sck),
        .i_sqi_cs (cs),
        .i_sqi_sio(sioIn),
        .o_sqi_sio(sioOut)
    );

    // System clock, 10 ns period.
    initial begin
        gck = 1'b0;
        forever #5 gck = ~gck;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One SCK pulse carrying nibble n; SCK high and low for two gck each.
    task automatic applyStimulus(input logic [3:0] n);
        @(negedge gck);
        sioIn = n;
        sck   = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b[7:4]);
        applyStimulus(b[3:0]);
    endtask

    task automatic sendPrefix(input logic [7:0] cmd, input logic [23:0] addr);
        sendByte(cmd);
        for (int i = 5; i >= 0; i--) applyStimulus(addr[i*4 +: 4]);
    endtask

    task automatic endTxn();
        @(negedge gck);
        cs = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    // WRITE burst of up to two bytes taken MSB-first from data.
    task automatic doWrite(input logic [23:0] addr, input int nBytes,
                           input logic [15:0] data);
        logic [7:0] b;
        cs = 1'b1;
        sendPrefix(8'h02, addr);
        for (int k = 0; k < nBytes; k++) begin
            b = (nBytes == 2 && k == 0) ? data[15:8] : data[7:0];
            sendByte(b);
            model[int'((32'(addr) + k) % DEPTH)] = b;
        end
        endTxn();
    endtask

    // READ burst; expected nibbles queued from the model before the prefix.
    task automatic doRead(input logic [23:0] addr, input int nBytes);
        int a;
        for (int k = 0; k < nBytes; k++) begin
            a = int'((32'(addr) + k) % DEPTH);
            expQ.push_back(model[a][7:4]);
            expQ.push_back(model[a][3:0]);
        end
        cs = 1'b1;
        sendPrefix(8'h03, addr);
`ifdef IDLI_SQI_MEM_DUMMY_EN
        applyStimulus(4'h0);
        applyStimulus(4'h0);
`endif
        for (int k = 0; k < 2 * nBytes; k++) begin
            if (k > 0) applyStimulus(4'h0);
            checkOutput("rd_nibble", {4'h0, sioOut}, {4'h0, expQ.pop_front()});
        end
        endTxn();
    endtask

    // Directed sequence covering reset, writes, reads, wrap and aborts.
    initial begin
        rst   = 1'b1;
        sck   = 1'b0;
        cs    = 1'b0;
        sioIn = 4'h0;
        repeat (3) @(negedge gck);
        checkOutput("reset_out", {4'h0, sioOut}, 8'h00);
        rst = 1'b0;

        // Idle with chip select low: SCK activity must be ignored.
        for (int i = 0; i < 4; i++) applyStimulus(4'h3);
        checkOutput("idle_out", {4'h0, sioOut}, 8'h00);

        // WRITE 0xA5, 0x3C at 0x10.
        doWrite(24'h000010, 2, 16'hA53C);
        checkOutput("wr_0x10", dut.data_q[16'h0010], 8'hA5);
        checkOutput("wr_0x11", dut.data_q[16'h0011], 8'h3C);

        // Reset pulse keeps memory contents.
        @(negedge gck);
        rst = 1'b1;
        @(negedge gck);
        rst = 1'b0;
        checkOutput("rst_keep_mem", dut.data_q[16'h0010], 8'hA5);
        checkOutput("rst_out", {4'h0, sioOut}, 8'h00);

        // READ burst from 0x10.
        doRead(24'h000010, 2);

        // WRITE burst across the top of memory, then READ it back.
        doWrite(24'h00FFFF, 2, 16'h1234);
        checkOutput("wr_top", dut.data_q[16'hFFFF], 8'h12);
        checkOutput("wr_wrap", dut.data_q[16'h0000], 8'h34);
        doRead(24'h00FFFF, 2);

        // Chip select dropped after 5 of 8 prefix nibbles, then a full READ.
        cs = 1'b1;
        sendByte(8'h03);
        for (int i = 0; i < 3; i++) applyStimulus(4'h0);
        endTxn();
        checkOutput("abort_out", {4'h0, sioOut}, 8'h00);
        doRead(24'h000010, 1);

        // Partial WRITE (high nibble only) must not change the target byte.
        doWrite(24'h000020, 1, 16'h005A);
        cs = 1'b1;
        sendPrefix(8'h02, 24'h000020);
        applyStimulus(4'hF);
        endTxn();
        checkOutput("partial_wr", dut.data_q[16'h0020], 8'h5A);
        doRead(24'h000020, 1);

        // Unknown command: output stays 0 and memory is untouched.
        cs = 1'b1;
        sendByte(8'hFF);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'hC);
            checkOutput("ignore_out", {4'h0, sioOut}, 8'h00);
        end
        endTxn();
        checkOutput("ignore_mem", dut.data_q[16'h0010], 8'hA5);
        checkOutput("ignore_mem2", dut.data_q[16'h0011], 8'h3C);

        // Reset asserted mid-READ clears the output asynchronously.
        cs = 1'b1;
        sendPrefix(8'h03, 24'h000010);
`ifdef IDLI_SQI_MEM_DUMMY_EN
        applyStimulus(4'h0);
        applyStimulus(4'h0);
`endif
        checkOutput("pre_rst_out", {4'h0, sioOut}, 8'h0A);
        #1 rst = 1'b1;
        #1 checkOutput("mid_rst_out", {4'h0, sioOut}, 8'h00);
        @(negedge gck);
        rst = 1'b0;
        endTxn();
        doRead(24'h000010, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
